// File: rtl/uart_bus_arbiter.sv
// uart_bus_arbiter: round-robin arbiter granting N requesters single-word
// access to a buffered UART (TX FIFO write / RX FIFO read).
// Optional feature: define UART_ARB_LOCK_EN to let the owner retain the
// round-robin pointer via req_lock. Without it, req_lock is ignored.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | arbitrate among eligible requesters, latch the winner
// ACCESS  | one-cycle UART strobe (write to tx_address / read rx_address)
// WAIT    | read only: UART read data settles
// DONE    | capture read data, pulse done, release grant, move pointer
module uart_bus_arbiter #(
  parameter int width         = 8,
  parameter int address_width = 4,
  parameter int requesters    = 4,
  parameter int rx_address    = 1,
  parameter int tx_address    = 2
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic [requesters-1:0]       req,
  input  logic [requesters-1:0]       req_write,
  input  logic [requesters*width-1:0] req_data,
  input  logic [requesters-1:0]       req_lock,
  output logic [requesters-1:0]       gnt,
  output logic [requesters-1:0]       done,
  output logic [width-1:0]            rd_data,
  input  logic                        rx_empty,
  input  logic                        tx_full,
  output logic [address_width-1:0]    active_address,
  output logic                        write_enable,
  output logic                        read_enable,
  output logic [width-1:0]            data_in,
  input  logic [width-1:0]            data_out
);

  localparam int IW = (requesters > 1) ? $clog2(requesters) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t                     state_q;
  logic [IW-1:0]              ptr_q;
  logic [IW-1:0]              win_q;
  logic                       wr_q;
  logic [requesters-1:0]      gnt_q;
  logic [requesters-1:0]      done_q;
  logic [width-1:0]           rd_data_q;
  logic [address_width-1:0]   addr_q;
  logic                       we_q;
  logic                       re_q;
  logic [width-1:0]           din_q;

  logic [requesters-1:0]      elig;
  logic                       found_d;
  logic [IW-1:0]              win_d;
  logic [requesters-1:0]      win_oh_d;
  logic [IW-1:0]              ptr_inc;

  // A requester is eligible only if its FIFO side can accept the transfer now
  always_comb begin
    elig = '0;
    for (int i = 0; i < requesters; i++) begin
      elig[i] = req[i] & (req_write[i] ? ~tx_full : ~rx_empty);
    end
  end

  // First eligible index at or after the pointer, wrapping N-1 -> 0
  always_comb begin
    found_d  = 1'b0;
    win_d    = '0;
    win_oh_d = '0;
    for (int k = 0; k < requesters; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % requesters;
      if (!found_d && elig[idx]) begin
        found_d       = 1'b1;
        win_d         = IW'(idx);
        win_oh_d      = '0;
        win_oh_d[idx] = 1'b1;
      end
    end
  end

  assign ptr_inc = (int'(win_q) == requesters - 1) ? '0 : win_q + 1'b1;

`ifndef UART_ARB_LOCK_EN
  logic unused_req_lock;
  assign unused_req_lock = ^req_lock;
`endif

  // Arbiter FSM with all bus-facing outputs registered
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      wr_q      <= 1'b0;
      gnt_q     <= '0;
      done_q    <= '0;
      rd_data_q <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      din_q     <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (found_d) begin
            win_q   <= win_d;
            wr_q    <= req_write[win_d];
            gnt_q   <= win_oh_d;
            state_q <= ST_ACCESS;
            if (req_write[win_d]) begin
              we_q   <= 1'b1;
              addr_q <= address_width'(tx_address);
              din_q  <= req_data[win_d*width +: width];
            end else begin
              re_q   <= 1'b1;
              addr_q <= address_width'(rx_address);
            end
          end
        end
        ST_ACCESS: begin
          we_q    <= 1'b0;
          re_q    <= 1'b0;
          addr_q  <= '0;
          din_q   <= '0;
          state_q <= wr_q ? ST_DONE : ST_WAIT;
        end
        ST_WAIT: begin
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          if (!wr_q) begin
            rd_data_q <= data_out;
          end
          done_q  <= gnt_q;
          gnt_q   <= '0;
          state_q <= ST_IDLE;
`ifdef UART_ARB_LOCK_EN
          ptr_q   <= req_lock[win_q] ? win_q : ptr_inc;
`else
          ptr_q   <= ptr_inc;
`endif
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt            = gnt_q;
  assign done           = done_q;
  assign rd_data        = rd_data_q;
  assign active_address = addr_q;
  assign write_enable   = we_q;
  assign read_enable    = re_q;
  assign data_in        = din_q;

endmodule

// File: doc/uart_bus_arbiter.md
UART_BUS_ARBITER -- requirements
Module: uart_bus_arbiter

Interface
REQ-001 Parameter width, default 8, UART data word width in bits.
REQ-002 Parameter address_width, default 4, bus address width in bits.
REQ-003 Parameter requesters, default 4, number of requester ports N (2..8).
REQ-004 Parameters rx_address (default 1) and tx_address (default 2), the buffered UART receive and transmit addresses.
REQ-005 Port: clock, input, 1, sole clock; all state updates on posedge.
REQ-006 Port: resetn, input, 1, asynchronous active-low reset.
REQ-007 Port: req, input, N, per-requester access request, held high until done.
REQ-008 Port: req_write, input, N, per-requester direction; 1 = write to TX FIFO, 0 = read from RX FIFO.
REQ-009 Port: req_data, input, N*width, per-requester write word, slice i at [i*width +: width].
REQ-010 Port: req_lock, input, N, per-requester ownership-retain request, used only under REQ-033.
REQ-011 Port: gnt, output, N, one-hot owner of the UART bus.
REQ-012 Port: done, output, N, one-cycle completion pulse to the owner.
REQ-013 Port: rd_data, output, width, word returned by the last completed read.
REQ-014 Port: rx_empty, input, 1, buffered UART RX FIFO empty.
REQ-015 Port: tx_full, input, 1, buffered UART TX FIFO full.
REQ-016 Port: active_address, output, address_width, UART bus address.
REQ-017 Port: write_enable / read_enable, output, 1 each, UART bus strobes.
REQ-018 Port: data_in, output, width, word to the UART; data_out, input, width, word from the UART.

Function
REQ-019 FSM states are IDLE, ACCESS, WAIT, DONE.
REQ-020 A requester is eligible when req[i]=1 and either (req_write[i]=1, tx_full=0) or (req_write[i]=0, rx_empty=0).
REQ-021 In IDLE, with any requester eligible, the arbiter latches the winner and its direction, sets gnt one-hot, and enters ACCESS.
REQ-022 The winner is the first eligible index at or after the round-robin pointer, wrapping N-1 -> 0.
REQ-023 In ACCESS, for exactly one cycle: active_address = tx_address and write_enable=1 with data_in = the winner's req_data for writes; active_address = rx_address and read_enable=1 for reads.
REQ-024 A write goes ACCESS -> DONE; a read goes ACCESS -> WAIT -> DONE.
REQ-025 In DONE, a read captures data_out into rd_data.
REQ-026 In DONE, the owner's done pulses for one cycle, gnt clears, the pointer becomes winner+1 mod N, and the FSM returns to IDLE.
REQ-027 Request-to-done latency is 3 cycles for writes and 4 cycles for reads, measured from the IDLE cycle in which eligibility is seen.
REQ-028 Outside ACCESS, write_enable=0, read_enable=0, and active_address=0.
REQ-029 Ineligible requesters are skipped, not blocked; with none eligible, the FSM stays in IDLE and drives no strobes.
REQ-030 If req drops after grant, the transaction still completes; no strobe is ever cancelled.
REQ-031 rd_data holds its value until the next read completes; writes do not alter it.

Reset
REQ-032 While resetn=0 (asynchronously): FSM=IDLE, pointer=0, gnt=0, done=0, rd_data=0, write_enable=0, read_enable=0, active_address=0, data_in=0; a transaction cut by reset is dropped without done.

Configuration
REQ-033 Macro UART_ARB_LOCK_EN; when defined, if req_lock[winner]=1 in DONE the pointer is left at the winner so it wins the next arbitration while eligible; when undefined, req_lock is ignored and the pointer always advances per REQ-026.

Verification
REQ-034 All four requesters request write 0xA0+i from reset, tx_full=0 -> grants in order 0,1,2,3; data_in 0xA0..0xA3; each done 3 cycles after its IDLE cycle.
REQ-035 Requester 2 reads, rx_empty=0, data_out=0x5C in the WAIT cycle -> read_enable one cycle with address 1; done[2] at cycle 4; rd_data=0x5C.
REQ-036 Requester 0 writes with tx_full=1, requester 1 reads with rx_empty=0 -> requester 1 served first; requester 0 is served after tx_full falls.
REQ-037 resetn pulled low during WAIT of a read -> all outputs 0 immediately, no done, next grant after release goes to index 0.
REQ-038 With UART_ARB_LOCK_EN, requester 1 locked with continuous writes while requester 2 requests -> requester 1 is granted back-to-back until req_lock[1]=0, then requester 2 is served; without the macro -> grants alternate 1,2.
